// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- multi-cycle radix-2 restoring divider for DIV/DIVU.
//
// The EX stage raises start_i with the operands, stalls while the divider
// runs, and consumes {remainder, quotient} once ready_o is high.  One quotient
// bit is produced per cycle; signed operation divides magnitudes and fixes
// the signs up on the final iteration.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend, sampled only when an operation starts
//   opdata2_i     divisor,  sampled only when an operation starts
//   start_i       request, held high until ready_o is seen
//   annul_i       abort the current operation (pipeline flush)
//   result_o      {remainder, quotient}, meaningful only while ready_o = 1
//   ready_o       result valid
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem;
  // Holds the dividend magnitude; its MSB is consumed each iteration while the
  // new quotient bit enters at the LSB, so after WIDTH steps it is the quotient.
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dsr;
  logic               neg_quo;
  logic               neg_rem;

  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   dvd_nxt;
  logic               last_iter;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return WIDTH'(0) - v;
  endfunction

  // Two's-complement magnitude; the most-negative value maps onto itself,
  // which as an unsigned magnitude is exactly right.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  // Partial remainder is always below 2*divisor, so a WIDTH+1-bit difference
  // has its MSB set exactly when the subtraction would go negative.
  always_comb begin
    partial   = {rem, dvd[WIDTH-1]};
    diff      = partial - {1'b0, dsr};
    fits      = ~diff[WIDTH];
    rem_nxt   = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    dvd_nxt   = {dvd[WIDTH-2:0], fits};
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      ready_o  <= 1'b0;
      result_o <= '0;
      cnt      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state   <= ON;
              cnt     <= '0;
              rem     <= '0;
              dvd     <= magnitude(opdata1_i, signed_div_i);
              dsr     <= magnitude(opdata2_i, signed_div_i);
              neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
            end
          end
        end

        BYZERO: begin
          state   <= END;
          rem     <= '0;
          dvd     <= '0;
          neg_quo <= 1'b0;
          neg_rem <= 1'b0;
        end

        ON: begin
          if (annul_i) begin
            state <= FREE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
              // Signs are applied together with the final quotient bit.
              state <= END;
              rem   <= neg_rem ? negate(rem_nxt) : rem_nxt;
              dvd   <= neg_quo ? negate(dvd_nxt) : dvd_nxt;
            end else begin
              rem <= rem_nxt;
              dvd <= dvd_nxt;
            end
          end
        end

        END: begin
          if (annul_i || !start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            ready_o  <= 1'b1;
            result_o <= {rem, dvd};
          end
        end

        default: begin
          state <= FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              signed_div_i = 1'b0;
  logic [WIDTH-1:0]  opdata1_i = '0;
  logic [WIDTH-1:0]  opdata2_i = '0;
  logic              start_i = 1'b0;
  logic              annul_i = 1'b0;
  logic [2*WIDTH-1:0] result_o;
  logic              ready_o;

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder
  // taking the dividend's sign, divide-by-zero giving all zeros.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'h0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  // Monitor: every rising ready_o must match the oldest expected response.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (ready_o && !prev) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready actual=1 required=0 result=%h", result_o);
          end else begin
            e = sb_q.pop_front();
            chk({e.name, "_result"}, result_o, e.res);
            chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
          end
        end else if (!ready_o) begin
          chk("idle_result_zero", result_o, 64'h0);
        end
        prev = ready_o;
      end
    end
  end

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b);
    exp_t e;
    int   n;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res  = ref_div(sgn, a, b);
    e.cyc  = cyc + ((b == 32'd0) ? 3 : WIDTH + 2);
    e.name = name;
    sb_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      // Operands after the start edge must have no effect.
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ready required=ready", name);
      sb_q.delete();
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    // Start still held: result must stay presented.
    @(negedge clk);
    chk({name, "_hold_ready"}, 64'(ready_o), 64'd1);
    chk({name, "_hold_result"}, result_o, e.res);
    start_i = 1'b0;
    @(negedge clk);
    chk({name, "_drop_ready"}, 64'(ready_o), 64'd0);
  endtask

  task automatic expect_quiet(input string name, input int ncyc);
    int seen;
    seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (ready_o) seen = 1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'h0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed cases
    run_div("u_100_7",    1'b0, 32'd100,        32'd7);
    run_div("s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'h2);
    run_div("u_m7_2",     1'b0, 32'hFFFF_FFF9,  32'h2);
    run_div("u_byzero",   1'b0, 32'h1234_5678,  32'h0);
    run_div("s_byzero",   1'b1, 32'h8000_0000,  32'h0);
    run_div("s_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF);
    run_div("s_min_1",    1'b1, 32'h8000_0000,  32'h1);
    run_div("s_m100_7",   1'b1, 32'hFFFF_FF9C,  32'd7);
    run_div("s_100_m7",   1'b1, 32'd100,        32'hFFFF_FFF9);
    run_div("u_max_1",    1'b0, 32'hFFFF_FFFF,  32'h1);
    run_div("u_small_big",1'b0, 32'd5,          32'hFFFF_FFFF);

    // Annul at iteration 10, then a clean 9/3
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    expect_quiet("annul_on_quiet", 40);
    run_div("u_9_3", 1'b0, 32'd9, 32'd3);

    // Annul wins over start in FREE
    @(negedge clk);
    opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    expect_quiet("annul_free_quiet", 40);

    // Annul while the result is presented
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd0; start_i = 1'b1;
    sb_q.push_back('{64'h0, cyc + 3, "annul_end"});
    repeat (4) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_end_ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a division, start held during reset
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_0000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    expect_quiet("rst_quiet", 40);
    run_div("after_rst", 1'b0, 32'd100, 32'd7);

    // Randomized
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 28);
      endcase
      run_div("rand", sgn, a, b);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
